// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM encoding, timeout width and
// the per-cycle stage control bundle with its issue-rule helper.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_LD_BUBBLE = 2'd1,
        ST_DMEM_WAIT = 2'd2,
        ST_ERR       = 2'd3
    } state_e;

    localparam int unsigned TO_W = 8;

    typedef struct packed {
        logic pc_en;
        logic pc_sel;
        logic en_de;
        logic en_exe;
        logic en_acc;
        logic en_wb;
        logic flush_de;
        logic flush_exe;
    } ctrl_t;

    // Priority rules applied when the data side is not stalling:
    // taken branch > load-use hazard > fetch miss > free flow.
    function automatic ctrl_t issue_ctrl(input logic br, input logic hz, input logic imem_ack);
        ctrl_t c;
        c = '{pc_en: 1'b1, pc_sel: 1'b0, en_de: 1'b1, en_exe: 1'b1,
              en_acc: 1'b1, en_wb: 1'b1, flush_de: 1'b0, flush_exe: 1'b0};
        if (br) begin
            c.pc_sel    = 1'b1;
            c.flush_de  = 1'b1;
            c.flush_exe = 1'b1;
        end else if (hz) begin
            c.pc_en     = 1'b0;
            c.en_de     = 1'b0;
            c.flush_exe = 1'b1;
        end else if (!imem_ack) begin
            c.pc_en    = 1'b0;
            c.flush_de = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// clr_i and inc_i together load 1; cnt_o stops at all-ones, flagged by sat_o.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         sat_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign sat_o = &cnt_q;
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = inc_i ? W'(1) : '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central 5-stage pipeline sequencer.
// Inputs : hz_stall, br_taken_exe, imem_ack, dmem_req_acc, dmem_ack, clk, rst (async, low).
// Outputs: imem_req, pc_en, pc_sel, en_de/exe/acc/wb, flush_de/exe (Mealy, zero in reset),
//          bus_err (sticky), state (debug), stall_cnt (saturating pc_en=0 cycle count).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DMEM_TIMEOUT = 15,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hz_stall,
    input  logic             br_taken_exe,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic             dmem_req_acc,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             en_de,
    output logic             en_exe,
    output logic             en_acc,
    output logic             en_wb,
    output logic             flush_de,
    output logic             flush_exe,
    output logic             bus_err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    state_e            state_q, state_d;
    logic              bus_err_q, bus_err_d;
    ctrl_t             ctrl;
    logic              imem_req_c;
    logic              to_clr, to_inc, to_sat;
    logic [TO_W-1:0]   to_cnt;
    logic              stall_inc, stall_sat;

    // Next state, timeout control and Mealy stage controls.
    always_comb begin
        state_d    = state_q;
        bus_err_d  = bus_err_q;
        ctrl       = '0;
        imem_req_c = 1'b0;
        to_clr     = 1'b1;
        to_inc     = 1'b0;
        unique case (state_q)
            ST_RUN, ST_LD_BUBBLE: begin
                imem_req_c = 1'b1;
                if (dmem_req_acc && !dmem_ack) begin
                    state_d = ST_DMEM_WAIT;
                    to_inc  = 1'b1;
                end else begin
                    // LD_BUBBLE masks the hazard unit's still-registered stall.
                    ctrl    = issue_ctrl(br_taken_exe, hz_stall && (state_q == ST_RUN), imem_ack);
                    state_d = (state_q == ST_RUN && !br_taken_exe && hz_stall) ? ST_LD_BUBBLE : ST_RUN;
                end
            end
            ST_DMEM_WAIT: begin
                imem_req_c = 1'b1;
                if (dmem_ack) begin
                    ctrl    = issue_ctrl(br_taken_exe, hz_stall, imem_ack);
                    state_d = ST_RUN;
                end else if (to_cnt == TO_W'(DMEM_TIMEOUT) || to_sat) begin
                    state_d   = ST_ERR;
                    bus_err_d = 1'b1;
                end else begin
                    to_clr = 1'b0;
                    to_inc = 1'b1;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
        endcase
        stall_inc = !ctrl.pc_en && (state_q != ST_ERR) && !stall_sat;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_err_q <= bus_err_d;
        end
    end

    sat_counter #(.W(TO_W)) u_timeout (
        .clk   (clk),
        .rst_n (rst),
        .clr_i (to_clr),
        .inc_i (to_inc),
        .cnt_o (to_cnt),
        .sat_o (to_sat)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .clr_i (1'b0),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt),
        .sat_o (stall_sat)
    );

    // Controls are forced low for as long as reset is held.
    assign imem_req  = rst & imem_req_c;
    assign pc_en     = rst & ctrl.pc_en;
    assign pc_sel    = rst & ctrl.pc_sel;
    assign en_de     = rst & ctrl.en_de;
    assign en_exe    = rst & ctrl.en_exe;
    assign en_acc    = rst & ctrl.en_acc;
    assign en_wb     = rst & ctrl.en_wb;
    assign flush_de  = rst & ctrl.flush_de;
    assign flush_exe = rst & ctrl.flush_exe;
    assign bus_err   = bus_err_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then randomized traffic,
// all compared against a cycle-level behavioural model of the sequencing rules.
module tb_pipe_ctrl;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned TMO   = 15;
    localparam int          SAT   = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             hz_stall, br_taken_exe, imem_ack, dmem_req_acc, dmem_ack;
    logic             imem_req, pc_en, pc_sel, en_de, en_exe, en_acc, en_wb;
    logic             flush_de, flush_exe, bus_err;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [8:0]       dut_ctrl;

    always #5 clk = ~clk;

    pipe_ctrl #(.DMEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .hz_stall     (hz_stall),
        .br_taken_exe (br_taken_exe),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .dmem_req_acc (dmem_req_acc),
        .dmem_ack     (dmem_ack),
        .pc_en        (pc_en),
        .pc_sel       (pc_sel),
        .en_de        (en_de),
        .en_exe       (en_exe),
        .en_acc       (en_acc),
        .en_wb        (en_wb),
        .flush_de     (flush_de),
        .flush_exe    (flush_exe),
        .bus_err      (bus_err),
        .state        (state),
        .stall_cnt    (stall_cnt)
    );

    assign dut_ctrl = {imem_req, pc_en, pc_sel, en_de, en_exe, en_acc, en_wb, flush_de, flush_exe};

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: 0 run, 1 bubble, 2 waiting on data memory, 3 dead.
    int         m_state, m_to, m_stall, nx_state, nx_to;
    bit         m_err, nx_err, nx_inc;
    logic [8:0] exp_ctrl;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_eval();
        bit ir, pe, ps, ed, ee, ea, ew, fd, fe;
        {ir, pe, ps, ed, ee, ea, ew, fd, fe} = 9'b0;
        nx_state = m_state;
        nx_to    = m_to;
        nx_err   = m_err;
        nx_inc   = 1'b0;
        if (m_state != 3) begin
            ir = 1'b1;
            if (m_state == 2 && !dmem_ack) begin
                if (m_to >= int'(TMO)) begin
                    nx_state = 3;
                    nx_err   = 1'b1;
                end else begin
                    nx_to = m_to + 1;
                end
            end else if (m_state != 2 && dmem_req_acc && !dmem_ack) begin
                nx_state = 2;
                nx_to    = 1;
            end else begin
                nx_state = 0;
                {pe, ed, ee, ea, ew} = 5'b11111;
                if (br_taken_exe) begin
                    ps = 1'b1; fd = 1'b1; fe = 1'b1;
                end else if (hz_stall && m_state != 1) begin
                    pe = 1'b0; ed = 1'b0; fe = 1'b1;
                    if (m_state == 0) nx_state = 1;
                end else if (!imem_ack) begin
                    pe = 1'b0; fd = 1'b1;
                end
            end
            nx_inc = !pe;
        end
        exp_ctrl = {ir, pe, ps, ed, ee, ea, ew, fd, fe};
    endtask

    // One clock: drive inputs, check Mealy outputs, advance, check registered state.
    task automatic step(input bit br_v, input bit hz_v, input bit ia_v, input bit rq_v, input bit da_v);
        br_taken_exe = br_v;
        hz_stall     = hz_v;
        imem_ack     = ia_v;
        dmem_req_acc = rq_v;
        dmem_ack     = da_v;
        #1;
        model_eval();
        check("ctrl", 32'(dut_ctrl), 32'(exp_ctrl));
        @(posedge clk);
        m_state = nx_state;
        m_to    = nx_to;
        m_err   = nx_err;
        if (nx_inc && m_stall < SAT) m_stall++;
        #1;
        check("state", 32'(state), 32'(m_state));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check("bus_err", 32'(bus_err), 32'(m_err));
    endtask

    // Asynchronous reset pulse mid-cycle with junk on the inputs.
    task automatic do_reset();
        rst          = 1'b0;
        hz_stall     = 1'($urandom);
        br_taken_exe = 1'($urandom);
        imem_ack     = 1'($urandom);
        dmem_req_acc = 1'($urandom);
        dmem_ack     = 1'($urandom);
        #1;
        check("rst_ctrl", 32'(dut_ctrl), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        m_state = 0; m_to = 0; m_stall = 0; m_err = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    int ack_pct;
    int err_age;

    initial begin
        rst = 1'b0;
        {hz_stall, br_taken_exe, imem_ack, dmem_req_acc, dmem_ack} = 5'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Free flow.
        repeat (10) step(0, 0, 1, 0, 0);
        check("idle_stall", 32'(stall_cnt), 32'd0);

        // Load-use stall held two cycles: one bubble only.
        step(0, 1, 1, 0, 0);
        check("hz_state", 32'(state), 32'd1);
        step(0, 1, 1, 0, 0);
        check("hz_stall_cnt", 32'(stall_cnt), 32'd1);

        // Data wait with branch pending; release applies branch redirect.
        do_reset();
        repeat (3) step(1, 0, 1, 1, 0);
        check("dw_state", 32'(state), 32'd2);
        step(1, 0, 1, 1, 1);
        check("dw_stall_cnt", 32'(stall_cnt), 32'd3);

        // Timeout into ERR, held until reset.
        do_reset();
        repeat (15) step(0, 0, 1, 1, 0);
        check("to_still_wait", 32'(state), 32'd2);
        step(0, 0, 1, 1, 0);
        check("to_err_state", 32'(state), 32'd3);
        check("to_bus_err", 32'(bus_err), 32'd1);
        repeat (4) step(1, 1, 1, 0, 1);
        #1;
        check("err_imem_req", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1;

        // Ack on the timeout cycle wins.
        do_reset();
        repeat (15) step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 1);
        check("to_ack_state", 32'(state), 32'd0);
        check("to_ack_bus_err", 32'(bus_err), 32'd0);

        // Branch overrides hazard and fetch miss.
        do_reset();
        step(1, 1, 0, 0, 0);
        check("br_state", 32'(state), 32'd0);

        // Stall counter saturation.
        do_reset();
        repeat (20) step(0, 0, 0, 0, 0);
        check("sat_stall", 32'(stall_cnt), 32'd15);

        // Reset in the middle of a data wait.
        do_reset();
        repeat (3) step(0, 0, 1, 1, 0);
        do_reset();
        step(0, 0, 1, 0, 0);
        check("post_rst_state", 32'(state), 32'd0);

        // Randomized traffic with phases of scarce dmem_ack.
        ack_pct = 50;
        err_age = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) ack_pct = ($urandom_range(0, 2) == 0) ? 3 : 50;
            if (m_state == 3) err_age++;
            else              err_age = 0;
            if ($urandom_range(0, 399) == 0 || err_age > 6) begin
                do_reset();
                err_age = 0;
            end
            step(($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0),
                 (32'($urandom_range(0, 99)) < 32'(ack_pct)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage rv32 core (IF, DE, EXE, ACC, WB). It drives the per-stage register enables, bubble/flush controls and PC select. Inputs are the forwarding unit's load-use stall, the EXE-stage branch resolution and the instruction/data memory handshakes. It owns a small FSM for load-use bubbles, data-memory waits and a fatal bus-timeout state, plus a stall performance counter.

Parameters:
DMEM_TIMEOUT, 15, max cycles DMEM_WAIT may last without dmem_ack before entering ERR (1..255)
CNT_W, 16, width of stall_cnt

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset
hz_stall  in  1  load-use hazard from forwarding unit (DE source depends on load in EXE)
br_taken_exe  in  1  branch/jump in EXE resolved taken
imem_req  out  1  fetch request
imem_ack  in  1  fetch data valid this cycle
dmem_req_acc  in  1  ACC-stage instruction is a load/store
dmem_ack  in  1  data memory completes access this cycle
pc_en  out  1  PC register update enable
pc_sel  out  1  1 = next PC is branch target, 0 = PC+4
en_de, en_exe, en_acc, en_wb  out  1 each  stage input register enables
flush_de  out  1  load a NOP into the DE register
flush_exe  out  1  load a NOP into the EXE register
bus_err  out  1  sticky timeout flag
state  out  2  current FSM state (debug)
stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- State and counters are registered. All enable/flush/pc_sel outputs are combinational from state and current inputs (Mealy), so they act in the same cycle.
- Reset (rst=0, async): state=RUN, bus_err=0, stall_cnt=0, timeout counter=0. While reset is asserted, all enables, flushes, pc_sel and imem_req are 0.
- States: RUN=0, LD_BUBBLE=1, DMEM_WAIT=2, ERR=3.
- Default in RUN/LD_BUBBLE: all en_*=1, pc_en=1, pc_sel=0, flushes=0, imem_req=1.
- Rule evaluation order in RUN; the first matching rule wins:
  1. dmem_req_acc && !dmem_ack: pc_en=0 and all en_*=0; next state DMEM_WAIT; timeout counter := 1.
  2. br_taken_exe: pc_sel=1, pc_en=1, flush_de=1, flush_exe=1, all en_*=1. Overrides hz_stall and imem_ack=0 (wrong-path fetch discarded).
  3. hz_stall: pc_en=0, en_de=0, flush_exe=1, en_exe/en_acc/en_wb=1; next state LD_BUBBLE.
  4. !imem_ack: pc_en=0, en_de=1, flush_de=1 (bubble into DE); downstream enables stay 1.
  5. Otherwise all enables are 1.
- LD_BUBBLE: same rules as RUN except hz_stall is ignored. This masks the hazard unit's registered stall for exactly one cycle. Unconditionally returns to RUN unless rule 1 fires.
- DMEM_WAIT: all enables and flushes are 0. imem_req stays 1 (fetch may complete but PC is held).
  - With dmem_ack=1: apply RUN rules 2–5 in the same cycle and go to RUN.
  - Without ack: the timeout counter increments. When the counter reaches DMEM_TIMEOUT with dmem_ack=0, go to ERR.
  - dmem_ack in the timeout cycle wins over entering ERR.
- ERR: all enables, flushes and imem_req are 0; bus_err=1. Exit only by reset.
- stall_cnt increments on every cycle with pc_en=0 in RUN, LD_BUBBLE or DMEM_WAIT. It saturates at all-ones and does not increment in ERR.
- Reset asserted mid-DMEM_WAIT clears everything immediately; no pending access is remembered.
- X on inputs during reset is ignored. After reset, inputs are assumed known each cycle.

Decomposition:
- pipe_ctrl_pkg: state encodings (ST_RUN, ST_LD_BUBBLE, ST_DMEM_WAIT, ST_ERR) and the timeout counter width constant (8).
- One sub-module, sat_counter (parameterised width, inc, clear, saturate flag), is instantiated twice: once for stall_cnt and once for the DMEM timeout.

Test Plan:
- Reset release, imem_ack=1, no hazards for 10 cycles -> all en_*=1, pc_en=1 every cycle, stall_cnt=0, state=0.
- hz_stall=1 held for 2 cycles -> cycle 1: pc_en=0, en_de=0, flush_exe=1, state->1; cycle 2: stall ignored, all en=1; stall_cnt=1.
- dmem_req_acc=1, dmem_ack=0 for 3 cycles then 1, with br_taken_exe=1 throughout -> 3 cycles all en=0 in state 2. Release cycle: pc_sel=1, flush_de=1, flush_exe=1; stall_cnt=3.
- dmem_req_acc=1, dmem_ack never, DMEM_TIMEOUT=15 -> state 2 for 15 cycles, then state=3, bus_err=1, imem_req=0. Holds until rst=0.
- br_taken_exe=1, hz_stall=1 and imem_ack=0 in the same RUN cycle -> pc_sel=1, pc_en=1, both flushes=1, state stays 0.
- stall_cnt with CNT_W=4 and 20 imem_ack=0 cycles -> saturates at 15. rst pulsed low mid-DMEM_WAIT -> outputs 0 immediately, state=0 after release.
